// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch unit and its neighbours: instruction memory,
// redirect source and decode. master = fetch unit side, slave = environment side.
interface fetch_unit_if #(
  parameter int XLEN   = 64,
  parameter int INST_W = 32
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [XLEN-1:0]   inst_pc;
  logic              misalign_err;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst, inst_pc,
    input  inst_ready,
    output misalign_err
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst, inst_pc,
    output inst_ready,
    input  misalign_err
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited in-order fetch, DEPTH-entry instruction queue, flushing redirects.
// Optional misaligned-redirect halt is enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
  parameter int              XLEN     = 64,
  parameter int              INST_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW+1:0] DEPTH_C = (CW+2)'(DEPTH);

  logic [XLEN-1:0]   r_fetch_pc;
  logic [XLEN-1:0]   r_rsp_pc;
  logic [XLEN-1:0]   r_q_pc   [DEPTH];
  logic [INST_W-1:0] r_q_inst [DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_live;
  logic [CW-1:0]     r_drop;

  logic              w_halted;
  logic [XLEN-1:0]   w_redirect_pc;
  logic [CW+1:0]     w_credit;
  logic              w_accept;
  logic              w_rsp_drop;
  logic              w_rsp_live;
  logic              w_push;
  logic              w_pop;

`ifdef FETCH_MISALIGN_CHECK_EN
  // state   | meaning
  // ST_RUN  | fetch requests may issue
  // ST_HALT | misaligned redirect seen; no issue, in-flight responses drained as drops
  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_misalign_err;
  logic   w_misalign_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= ST_RUN;
      r_misalign_err <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_misalign_err <= w_misalign_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_misalign_nxt = r_misalign_err;
    if (bus.redirect_valid) begin
      if (bus.redirect_pc[1:0] != 2'b00) begin
        w_state_nxt    = ST_HALT;
        w_misalign_nxt = 1'b1;
      end else begin
        w_state_nxt    = ST_RUN;
        w_misalign_nxt = 1'b0;
      end
    end
  end

  assign w_halted         = (r_state == ST_HALT);
  assign bus.misalign_err = r_misalign_err;
  assign w_redirect_pc    = bus.redirect_pc;
`else
  logic [1:0] w_unused_lsb;

  assign w_unused_lsb     = bus.redirect_pc[1:0];
  assign w_halted         = 1'b0;
  assign bus.misalign_err = 1'b0;
  assign w_redirect_pc    = {bus.redirect_pc[XLEN-1:2], 2'b00};
`endif

  // Requests are only issued when every outstanding or buffered fetch has a queue slot.
  assign w_credit           = {2'b00, r_live} + {2'b00, r_drop} + {2'b00, r_count};
  assign bus.imem_req_valid = rst & ~w_halted & (w_credit < DEPTH_C);
  assign bus.imem_req_addr  = r_fetch_pc;

  assign bus.inst_valid = rst & (r_count != '0);
  assign bus.inst       = r_q_inst[r_rd_ptr];
  assign bus.inst_pc    = r_q_pc[r_rd_ptr];

  assign w_accept   = bus.imem_req_valid & bus.imem_req_ready;
  assign w_rsp_drop = bus.imem_rsp_valid & (r_drop != '0);
  assign w_rsp_live = bus.imem_rsp_valid & (r_drop == '0) & (r_live != '0);
  assign w_push     = w_rsp_live & ~bus.redirect_valid;
  assign w_pop      = bus.inst_valid & bus.inst_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_live     <= '0;
      r_drop     <= '0;
    end else if (bus.redirect_valid) begin
      // Everything still in flight, including this cycle's accept, becomes a drop.
      r_fetch_pc <= w_redirect_pc;
      r_rsp_pc   <= w_redirect_pc;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_live     <= '0;
      r_drop     <= r_drop + r_live + CW'(w_accept) - CW'(w_rsp_drop | w_rsp_live);
    end else begin
      if (w_accept) r_fetch_pc <= r_fetch_pc + XLEN'(4);
      if (w_push) begin
        r_rsp_pc <= r_rsp_pc + XLEN'(4);
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_live  <= r_live + CW'(w_accept) - CW'(w_rsp_live);
      r_drop  <= r_drop - CW'(w_rsp_drop);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_rsp_pc;
      r_q_inst[r_wr_ptr] <= bus.imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with random latency, decode sink, fetch-stream scoreboard.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int          XLEN     = 64;
  localparam int          INST_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN), .INST_W(INST_W)) bus ();

  fetch_unit #(.XLEN(XLEN), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { logic [63:0] addr; int due; bit live; } mem_t;
  typedef struct { logic [63:0] pc; logic [31:0] inst; } exp_t;
  typedef struct {
    logic [63:0] pc; int lmin; int lmax; int rdy; int dec; int cycles;
    logic err; bit pops; logic [63:0] first; int min_pops;
  } vec_t;

  mem_t        mem_q[$];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_fetch = RESET_PC;
  bit          exp_halt = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1, lat_max = 1, rdy_pct = 100, dec_pct = 100;
  bit          redir_req = 0;
  logic [63:0] redir_target = '0;
  int          n_acc = 0, n_pop = 0;
  bit          acc_now = 0, rsp_now = 0, prev_redirect = 0, got_pop = 0;
  logic [63:0] first_pop_pc = '0;

  function automatic logic [31:0] mdata(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [63:0] eff_target(input logic [63:0] t);
`ifdef FETCH_MISALIGN_CHECK_EN
    return t;
`else
    return {t[63:2], 2'b00};
`endif
  endfunction

  function automatic bit halts_on(input logic [63:0] t);
`ifdef FETCH_MISALIGN_CHECK_EN
    return t[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive();
    @(posedge clk);
    #1;
    cyc++;
    bus.imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
    bus.inst_ready     = ($urandom_range(0, 99) < dec_pct);
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mdata(mem_q[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    bus.redirect_valid = redir_req;
    bus.redirect_pc    = redir_target;
    redir_req          = 0;
  endtask

  task automatic eval();
    int   live_mem;
    int   d;
    @(negedge clk);
    live_mem = 0;
    foreach (mem_q[i]) if (mem_q[i].live) live_mem++;
    chk("credit_bound", 64'((mem_q.size() + sb.size() - live_mem) <= DEPTH), 64'd1);
    if (exp_halt) begin
      chk("halt_req_valid", 64'(bus.imem_req_valid), 64'd0);
      chk("halt_inst_valid", 64'(bus.inst_valid), 64'd0);
    end
    if (prev_redirect && !exp_halt) begin
      chk("redir_inst_valid", 64'(bus.inst_valid), 64'd0);
      chk("redir_req_addr", bus.imem_req_addr, exp_fetch);
    end
    if (bus.inst_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stale_inst: inst_pc %h presented, expected no instruction", bus.inst_pc);
      end else begin
        chk("inst_pc", bus.inst_pc, sb[0].pc);
        chk("inst", 64'(bus.inst), 64'(sb[0].inst));
      end
      if (bus.inst_ready) begin
        if (sb.size() != 0) sb.delete(0);
        n_pop++;
        if (!got_pop) begin
          got_pop      = 1;
          first_pop_pc = bus.inst_pc;
        end
      end
    end
    acc_now = bus.imem_req_valid && bus.imem_req_ready;
    rsp_now = bus.imem_rsp_valid;
    if (acc_now) begin
      chk("req_addr", bus.imem_req_addr, exp_fetch);
      d = cyc + $urandom_range(lat_min, lat_max);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mem_q.push_back('{addr: bus.imem_req_addr, due: d, live: !bus.redirect_valid});
      if (!bus.redirect_valid) begin
        sb.push_back('{pc: exp_fetch, inst: mdata(exp_fetch)});
        exp_fetch = exp_fetch + 64'd4;
      end
      n_acc++;
    end
    if (rsp_now && mem_q.size() != 0) mem_q.delete(0);
    if (bus.redirect_valid) begin
      sb.delete();
      foreach (mem_q[i]) mem_q[i].live = 0;
      exp_fetch = eff_target(bus.redirect_pc);
      exp_halt  = halts_on(bus.redirect_pc);
      got_pop   = 0;
    end
    prev_redirect = bus.redirect_valid;
  endtask

  task automatic step();
    drive();
    eval();
  endtask

  task automatic do_redirect(input logic [63:0] t);
    redir_req    = 1;
    redir_target = t;
    step();
  endtask

  vec_t vt[6];
  int   c_acc, c_val;
  int   waited;

  initial begin
    bus.imem_req_ready = 0;
    bus.imem_rsp_valid = 0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 0;

    vt[0] = '{64'h8000_1000, 1, 3, 60, 70, 300, 1'b0, 1, 64'h8000_1000, 50};
`ifdef FETCH_MISALIGN_CHECK_EN
    vt[1] = '{64'h8000_0102, 1, 1, 100, 100, 20, 1'b1, 0, 64'h0, 0};
`else
    vt[1] = '{64'h8000_0102, 1, 1, 100, 100, 20, 1'b0, 1, 64'h8000_0100, 10};
`endif
    vt[2] = '{64'h8000_0200, 1, 1, 100, 100, 20, 1'b0, 1, 64'h8000_0200, 10};
    vt[3] = '{64'hFFFF_FFFF_FFFF_FFF8, 1, 2, 100, 100, 30, 1'b0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 10};
    vt[4] = '{64'h8000_0300, 2, 3, 50, 40, 300, 1'b0, 1, 64'h8000_0300, 30};
    vt[5] = '{64'h8000_0700, 1, 3, 100, 100, 100, 1'b0, 1, 64'h8000_0700, 50};

    // reset
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
      chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
      chk("rst_misalign", 64'(bus.misalign_err), 64'd0);
    end
    rst = 1'b1;

    // latency 1, decode always ready: 2-cycle latency then one instruction per cycle
    c_acc = -1;
    c_val = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (i == 0) chk("first_req_valid", 64'(bus.imem_req_valid), 64'd1);
      if (c_acc < 0 && acc_now) c_acc = cyc;
      if (c_val < 0 && bus.inst_valid) c_val = cyc;
      if (i == 9) n_pop = 0;
    end
    chk("first_latency", 64'(c_val - c_acc), 64'd2);
    chk("throughput", 64'(n_pop), 64'd20);

    // decode stalled: queue fills, issue stops, resumes right after a pop
    dec_pct = 0;
    do_redirect(64'h8000_0400);
    n_acc = 0;
    repeat (12) step();
    chk("full_accepts", 64'(n_acc), 64'd4);
    chk("full_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("full_inst_valid", 64'(bus.inst_valid), 64'd1);
    dec_pct = 100;
    step();
    step();
    chk("resume_req_valid", 64'(bus.imem_req_valid), 64'd1);
    repeat (10) step();

    // latency 3: redirect with requests in flight
    lat_min = 3;
    lat_max = 3;
    waited  = 0;
    while (mem_q.size() < 2 && waited < 20) begin
      step();
      waited++;
    end
    chk("lat3_inflight", 64'(mem_q.size() >= 2), 64'd1);
    do_redirect(64'h8000_0100);
    repeat (15) step();
    chk("lat3_got_pop", 64'(got_pop), 64'd1);
    chk("lat3_first_pc", first_pop_pc, 64'h8000_0100);

    // redirect coincident with an accept and a response
    lat_min = 1;
    lat_max = 1;
    repeat (8) step();
    do_redirect(64'h8000_0500);
    chk("coinc_accept", 64'(acc_now), 64'd1);
    chk("coinc_rsp", 64'(rsp_now), 64'd1);
    repeat (10) step();
    chk("coinc_first_pc", first_pop_pc, 64'h8000_0500);

    // table-driven phases with random handshakes
    foreach (vt[k]) begin
      lat_min = vt[k].lmin;
      lat_max = vt[k].lmax;
      rdy_pct = vt[k].rdy;
      dec_pct = vt[k].dec;
      do_redirect(vt[k].pc);
      n_pop = 0;
      n_acc = 0;
      repeat (vt[k].cycles) step();
      chk("vec_misalign", 64'(bus.misalign_err), 64'(vt[k].err));
      if (vt[k].pops) begin
        chk("vec_first_pc", first_pop_pc, vt[k].first);
        chk("vec_min_pops", 64'(n_pop >= vt[k].min_pops), 64'd1);
      end else begin
        chk("vec_no_accepts", 64'(n_acc), 64'd0);
        chk("vec_no_pops", 64'(n_pop), 64'd0);
        chk("vec_req_valid", 64'(bus.imem_req_valid), 64'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
